// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FIFO between a UART engine and the UART register block.
//
// The engine's single-byte holding register is drained into a 16 x 9-bit FIFO
// ({error, data}) as soon as a byte is available. The block-side interface
// mirrors the engine's own rx_data / rx_avail / rx_error / rx_ack handshake.
// The output is first-word-fall-through.
//
// Optional build macro: UART_RX_FIFO_WATERMARK_EN adds the rts_n flow-control
// output, with HIGH_WM / LOW_WM hysteresis.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   uart_rx_data   byte from the engine
//   uart_rx_avail  engine holding register full (a level, held until acked)
//   uart_rx_error  framing error flag for uart_rx_data
//   uart_rx_ack    registered one-cycle pulse that pops the engine register
//   rx_data        head-of-FIFO byte (combinational)
//   rx_error       error flag stored with the head byte (combinational)
//   rx_avail       FIFO not empty
//   rx_ack         one-cycle pop request from the register block
//   flush          synchronous clear of contents and overflow
//   level          current entry count, 0..16
//   overflow       sticky: at least one byte was dropped
//   rts_n          flow control, low = ready (watermark build only)
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
`ifdef UART_RX_FIFO_WATERMARK_EN
  ,
  parameter int HIGH_WM = 12,
  parameter int LOW_WM  = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_avail,
  input  logic                  uart_rx_error,
  output logic                  uart_rx_ack,
  output logic [7:0]            rx_data,
  output logic                  rx_error,
  output logic                  rx_avail,
  input  logic                  rx_ack,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
`ifdef UART_RX_FIFO_WATERMARK_EN
  ,
  output logic                  rts_n
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_L    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO_L = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE_L  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO_L = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE_L  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } cap_state_t;

  cap_state_t state_r, state_next_s;

  logic [8:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  logic [DEPTH_LOG2:0]   level_r, level_next_s;
  logic                  overflow_r, overflow_next_s;
  logic                  uart_rx_ack_r;
  logic                  capture_s, pop_s, push_ok_s, write_s;

  // Capture FSM: take one byte per assertion of uart_rx_avail, then wait for
  // the engine to drop the level so a stale level is never captured twice.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (uart_rx_avail) begin
          capture_s    = 1'b1;
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!uart_rx_avail) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Pointer / level / overflow next-state; flush overrides push and pop.
  // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
  always_comb begin
    pop_s           = rx_ack && (level_r != LVL_ZERO_L);
    push_ok_s       = capture_s && ((level_r != FULL_L) || pop_s);
    write_s         = push_ok_s && !flush;
    wr_ptr_next_s   = wr_ptr_r;
    rd_ptr_next_s   = rd_ptr_r;
    level_next_s    = level_r;
    overflow_next_s = overflow_r;
    if (flush) begin
      wr_ptr_next_s   = PTR_ZERO_L;
      rd_ptr_next_s   = PTR_ZERO_L;
      level_next_s    = LVL_ZERO_L;
      overflow_next_s = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_next_s = wr_ptr_r + PTR_ONE_L;
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + PTR_ONE_L;
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      if (push_ok_s && !pop_s) begin
        level_next_s = level_r + LVL_ONE_L;
      end else if (pop_s && !push_ok_s) begin
        level_next_s = level_r - LVL_ONE_L;
      end else begin
        level_next_s = level_r;
      end
      if (capture_s && !push_ok_s) begin
        overflow_next_s = 1'b1;
      end else begin
        overflow_next_s = overflow_r;
      end
    end
  end

  // Control state registers; the ack pulse is registered from the capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      wr_ptr_r      <= PTR_ZERO_L;
      rd_ptr_r      <= PTR_ZERO_L;
      level_r       <= LVL_ZERO_L;
      overflow_r    <= 1'b0;
      uart_rx_ack_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      wr_ptr_r      <= wr_ptr_next_s;
      rd_ptr_r      <= rd_ptr_next_s;
      level_r       <= level_next_s;
      overflow_r    <= overflow_next_s;
      uart_rx_ack_r <= capture_s;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= {uart_rx_error, uart_rx_data};
    end
  end

  assign rx_data     = mem_r[rd_ptr_r][7:0];
  assign rx_error    = mem_r[rd_ptr_r][8];
  assign rx_avail    = (level_r != LVL_ZERO_L);
  assign uart_rx_ack = uart_rx_ack_r;
  assign level       = level_r;
  assign overflow    = overflow_r;

`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam logic [DEPTH_LOG2:0] HIGH_WM_L = HIGH_WM[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LOW_WM_L  = LOW_WM[DEPTH_LOG2:0];

  logic rts_n_r;

  // rts_n hysteresis evaluated on the level being written this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rts_n_r <= 1'b0;
    end else if (flush) begin
      rts_n_r <= 1'b0;
    end else if (level_next_s >= HIGH_WM_L) begin
      rts_n_r <= 1'b1;
    end else if (level_next_s <= LOW_WM_L) begin
      rts_n_r <= 1'b0;
    end else begin
      rts_n_r <= rts_n_r;
    end
  end

  assign rts_n = rts_n_r;
`endif

endmodule
